// File: rtl/oursring_sd_bridge_pkg.sv
// Shared serial-debug record types and bridge state encoding.
package oursring_typedef;

    typedef enum logic [1:0] {
        ST_RD  = 2'd0,
        ST_WR  = 2'd1,
        ST_RSP = 2'd2,
        ST_ERR = 2'd3
    } st_type_e;

    typedef struct packed {
        st_type_e    typ;
        logic [39:0] addr;
        logic [63:0] data;
    } sd_info_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } sd_bridge_state_e;

    localparam logic [63:0] SD_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/oursring_sd_bridge_timeout.sv
// Response-wait counter: clear/enable controlled, flags the last allowed cycle.
module oursring_sd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/oursring_sd_bridge.sv
// Turns serial-debug read/write records into single oursring transactions and
// returns one response record per request, with timeout and late-response drain.
module oursring_sd_bridge
    import oursring_typedef::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sd_req_valid,
    output logic                 sd_req_ready,
    input  sd_info_t             sd_req_info,
    output logic                 sd_rsp_valid,
    input  logic                 sd_rsp_ready,
    output sd_info_t             sd_rsp_info,
    output logic                 ring_req_valid,
    input  logic                 ring_req_ready,
    output logic                 ring_req_wr,
    output logic [39:0]          ring_req_addr,
    output logic [63:0]          ring_req_data,
    input  logic                 ring_rsp_valid,
    output logic                 ring_rsp_ready,
    input  logic [63:0]          ring_rsp_data,
    input  logic                 ring_rsp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    sd_bridge_state_e     state, state_nxt;
    logic                 drain, drain_nxt;
    logic                 sd_rsp_valid_nxt;
    sd_info_t             sd_rsp_info_nxt;
    logic                 ring_req_valid_nxt;
    logic                 ring_req_wr_nxt;
    logic [39:0]          ring_req_addr_nxt;
    logic [63:0]          ring_req_data_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;
    logic                 to_clr, to_en, to_expired;
    logic                 req_bad;

    oursring_sd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    assign sd_req_ready   = (state == S_IDLE);
    assign ring_rsp_ready = (state == S_WAIT) || drain;
    assign busy           = (state != S_IDLE);
    assign req_bad        = (sd_req_info.typ == ST_RSP) || (sd_req_info.typ == ST_ERR) ||
                            (sd_req_info.addr[2:0] != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            drain          <= 1'b0;
            sd_rsp_valid   <= 1'b0;
            sd_rsp_info    <= '0;
            ring_req_valid <= 1'b0;
            ring_req_wr    <= 1'b0;
            ring_req_addr  <= '0;
            ring_req_data  <= '0;
            err_cnt        <= '0;
        end else begin
            state          <= state_nxt;
            drain          <= drain_nxt;
            sd_rsp_valid   <= sd_rsp_valid_nxt;
            sd_rsp_info    <= sd_rsp_info_nxt;
            ring_req_valid <= ring_req_valid_nxt;
            ring_req_wr    <= ring_req_wr_nxt;
            ring_req_addr  <= ring_req_addr_nxt;
            ring_req_data  <= ring_req_data_nxt;
            err_cnt        <= err_cnt_nxt;
        end
    end

    // ring_req_addr/wr stay loaded after the ring handshake and supply the response record.
    always_comb begin
        state_nxt          = state;
        drain_nxt          = drain;
        sd_rsp_valid_nxt   = sd_rsp_valid;
        sd_rsp_info_nxt    = sd_rsp_info;
        ring_req_valid_nxt = ring_req_valid;
        ring_req_wr_nxt    = ring_req_wr;
        ring_req_addr_nxt  = ring_req_addr;
        ring_req_data_nxt  = ring_req_data;
        err_cnt_nxt        = err_cnt;
        to_clr             = 1'b0;
        to_en              = 1'b0;

        case (state)
            S_IDLE: begin
                if (sd_req_valid) begin
                    if (req_bad) begin
                        sd_rsp_valid_nxt     = 1'b1;
                        sd_rsp_info_nxt.typ  = ST_ERR;
                        sd_rsp_info_nxt.addr = sd_req_info.addr;
                        sd_rsp_info_nxt.data = '0;
                        state_nxt            = S_RSP;
                    end else begin
                        ring_req_valid_nxt = 1'b1;
                        ring_req_wr_nxt    = (sd_req_info.typ == ST_WR);
                        ring_req_addr_nxt  = sd_req_info.addr;
                        ring_req_data_nxt  = (sd_req_info.typ == ST_WR) ? sd_req_info.data : '0;
                        state_nxt          = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (ring_req_ready) begin
                    ring_req_valid_nxt = 1'b0;
                    to_clr             = 1'b1;
                    state_nxt          = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ring_rsp_valid) begin
                    if (drain) begin
                        drain_nxt = 1'b0;
                        to_clr    = 1'b1;
                    end else begin
                        sd_rsp_valid_nxt     = 1'b1;
                        sd_rsp_info_nxt.typ  = ring_rsp_err ? ST_ERR : ST_RSP;
                        sd_rsp_info_nxt.addr = ring_req_addr;
                        sd_rsp_info_nxt.data = (!ring_req_wr && !ring_rsp_err) ? ring_rsp_data : '0;
                        state_nxt            = S_RSP;
                    end
                end else if (to_expired) begin
                    sd_rsp_valid_nxt     = 1'b1;
                    sd_rsp_info_nxt.typ  = ST_ERR;
                    sd_rsp_info_nxt.addr = ring_req_addr;
                    sd_rsp_info_nxt.data = SD_TIMEOUT_DATA;
                    drain_nxt            = 1'b1;
                    state_nxt            = S_RSP;
                end else begin
                    to_en = 1'b1;
                end
            end
            S_RSP: begin
                if (sd_rsp_ready) begin
                    sd_rsp_valid_nxt = 1'b0;
                    state_nxt        = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if ((state != S_WAIT) && ring_rsp_valid && drain) begin
            drain_nxt = 1'b0;
        end

        if (sd_rsp_valid && sd_rsp_ready && (sd_rsp_info.typ == ST_ERR) && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_oursring_sd_bridge.sv
// Directed checks of the serial-debug to oursring bridge with hand-computed expectations.
module tb_oursring_sd_bridge;
    import oursring_typedef::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd_req_valid;
    logic        sd_req_ready;
    sd_info_t    sd_req_info;
    logic        sd_rsp_valid;
    logic        sd_rsp_ready;
    sd_info_t    sd_rsp_info;
    logic        ring_req_valid;
    logic        ring_req_ready;
    logic        ring_req_wr;
    logic [39:0] ring_req_addr;
    logic [63:0] ring_req_data;
    logic        ring_rsp_valid;
    logic        ring_rsp_ready;
    logic [63:0] ring_rsp_data;
    logic        ring_rsp_err;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    oursring_sd_bridge #(
        .TIMEOUT_CYCLES(8),
        .ERR_CNT_W     (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sd_req_valid   (sd_req_valid),
        .sd_req_ready   (sd_req_ready),
        .sd_req_info    (sd_req_info),
        .sd_rsp_valid   (sd_rsp_valid),
        .sd_rsp_ready   (sd_rsp_ready),
        .sd_rsp_info    (sd_rsp_info),
        .ring_req_valid (ring_req_valid),
        .ring_req_ready (ring_req_ready),
        .ring_req_wr    (ring_req_wr),
        .ring_req_addr  (ring_req_addr),
        .ring_req_data  (ring_req_data),
        .ring_rsp_valid (ring_rsp_valid),
        .ring_rsp_ready (ring_rsp_ready),
        .ring_rsp_data  (ring_rsp_data),
        .ring_rsp_err   (ring_rsp_err),
        .busy           (busy),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic sd_info_t mk(input st_type_e t, input logic [39:0] a, input logic [63:0] d);
        sd_info_t r;
        r.typ  = t;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // One response handshake from S_RSP back to S_IDLE.
    task automatic hs();
        sd_rsp_ready = 1'b1;
        step();
        sd_rsp_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        sd_req_valid   = 1'b0;
        sd_req_info    = '0;
        sd_rsp_ready   = 1'b0;
        ring_req_ready = 1'b0;
        ring_rsp_valid = 1'b0;
        ring_rsp_data  = '0;
        ring_rsp_err   = 1'b0;
        step();
        step();
        chk("reset_outs", {sd_rsp_valid, ring_req_valid, ring_req_wr, busy, sd_req_ready, ring_rsp_ready},
            6'b000010);
        chk("reset_info", sd_rsp_info, '0);
        chk("reset_ring", {ring_req_addr, ring_req_data, err_cnt}, '0);
        rst = 1'b0;
        step();

        // 1: aligned read, response arrives one cycle after the request is taken
        sd_req_valid   = 1'b1;
        sd_req_info    = mk(ST_RD, 40'h10_0000_0008, 64'hDEAD);
        ring_req_ready = 1'b1;
        step();
        sd_req_valid = 1'b0;
        chk("rd_req", {ring_req_valid, ring_req_wr, ring_req_addr, ring_req_data, busy, sd_req_ready},
            {1'b1, 1'b0, 40'h10_0000_0008, 64'h0, 1'b1, 1'b0});
        ring_rsp_valid = 1'b1;
        ring_rsp_data  = 64'h1234_5678_9ABC_DEF0;
        step();
        chk("rd_wait", {ring_req_valid, ring_rsp_ready, sd_rsp_valid}, 3'b010);
        step();
        ring_rsp_valid = 1'b0;
        chk("rd_rsp_valid", sd_rsp_valid, 1'b1);
        chk("rd_rsp_info", sd_rsp_info, mk(ST_RSP, 40'h10_0000_0008, 64'h1234_5678_9ABC_DEF0));
        hs();
        chk("rd_done", {sd_rsp_valid, busy, err_cnt}, {1'b0, 1'b0, 8'd0});

        // 2: write held off by ring backpressure for five cycles
        ring_req_ready = 1'b0;
        sd_req_valid   = 1'b1;
        sd_req_info    = mk(ST_WR, 40'h20, 64'hA5A5);
        step();
        sd_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold", {ring_req_valid, ring_req_wr, ring_req_addr, ring_req_data, sd_rsp_valid},
                {1'b1, 1'b1, 40'h20, 64'hA5A5, 1'b0});
            step();
        end
        ring_req_ready = 1'b1;
        step();
        chk("wr_taken", {ring_req_valid, ring_rsp_ready}, 2'b01);
        ring_rsp_valid = 1'b1;
        ring_rsp_data  = 64'h5555_5555;
        step();
        ring_rsp_valid = 1'b0;
        chk("wr_rsp", {sd_rsp_valid, sd_rsp_info}, {1'b1, mk(ST_RSP, 40'h20, 64'h0)});
        hs();

        // 3: misaligned and illegal-type requests never reach the ring
        sd_req_valid = 1'b1;
        sd_req_info  = mk(ST_RD, 40'h3, 64'h77);
        step();
        sd_req_valid = 1'b0;
        chk("mis_rsp", {ring_req_valid, sd_rsp_valid, sd_rsp_info}, {1'b0, 1'b1, mk(ST_ERR, 40'h3, 64'h0)});
        hs();
        chk("mis_cnt", err_cnt, 8'd1);
        sd_req_valid = 1'b1;
        sd_req_info  = mk(ST_RSP, 40'h8, 64'h99);
        step();
        sd_req_valid = 1'b0;
        chk("ill_rsp", {ring_req_valid, sd_rsp_valid, sd_rsp_info}, {1'b0, 1'b1, mk(ST_ERR, 40'h8, 64'h0)});
        hs();
        chk("ill_cnt", err_cnt, 8'd2);

        // 4: no ring response; timeout after 8 cycles in S_WAIT, then drain a late response
        sd_req_valid = 1'b1;
        sd_req_info  = mk(ST_RD, 40'h40, 64'h0);
        step();
        sd_req_valid = 1'b0;
        step();
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_pending", sd_rsp_valid, 1'b0);
        end
        step();
        chk("to_rsp", {sd_rsp_valid, sd_rsp_info}, {1'b1, mk(ST_ERR, 40'h40, 64'hFFFF_FFFF_FFFF_FFFF)});
        chk("to_drain_rdy", ring_rsp_ready, 1'b1);
        hs();
        chk("to_cnt", {err_cnt, busy, ring_rsp_ready}, {8'd3, 1'b0, 1'b1});
        ring_rsp_valid = 1'b1;
        ring_rsp_data  = 64'hBAD;
        step();
        ring_rsp_valid = 1'b0;
        chk("drain_done", {ring_rsp_ready, sd_rsp_valid, busy}, 3'b000);
        step();
        chk("drain_quiet", {ring_rsp_ready, sd_rsp_valid}, 2'b00);

        // 5: ring error on a read with the front end stalling the response
        sd_req_valid   = 1'b1;
        sd_req_info    = mk(ST_RD, 40'h48, 64'h0);
        ring_rsp_valid = 1'b1;
        ring_rsp_err   = 1'b1;
        ring_rsp_data  = 64'hFFFF_0000_1111_2222;
        step();
        sd_req_valid = 1'b0;
        step();
        step();
        ring_rsp_valid = 1'b0;
        ring_rsp_err   = 1'b0;
        chk("rerr_rsp", {sd_rsp_valid, sd_rsp_info}, {1'b1, mk(ST_ERR, 40'h48, 64'h0)});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rerr_hold", {sd_rsp_valid, sd_rsp_info, err_cnt}, {1'b1, mk(ST_ERR, 40'h48, 64'h0), 8'd3});
        end
        hs();
        chk("rerr_cnt", {sd_rsp_valid, err_cnt}, {1'b0, 8'd4});
        sd_req_info  = mk(ST_RD, 40'h5, 64'h0);
        sd_req_valid = 1'b1;
        sd_rsp_ready = 1'b1;
        for (int i = 0; i < 251 * 2; i++) begin
            step();
        end
        sd_req_valid = 1'b0;
        chk("sat_reach", {err_cnt, busy}, {8'd255, 1'b0});
        sd_req_valid = 1'b1;
        step();
        sd_req_valid = 1'b0;
        step();
        sd_rsp_ready = 1'b0;
        chk("sat_hold", {err_cnt, busy}, {8'd255, 1'b0});

        // 6: asynchronous reset in S_WAIT, then a read that sees a response with drain clear
        sd_req_valid   = 1'b1;
        sd_req_info    = mk(ST_RD, 40'h50, 64'h0);
        ring_req_ready = 1'b1;
        step();
        sd_req_valid = 1'b0;
        step();
        chk("rst_pre", {busy, ring_rsp_ready, ring_req_valid}, 3'b110);
        rst = 1'b1;
        #1;
        chk("rst_async_ctl", {sd_rsp_valid, ring_req_valid, ring_req_wr, busy, sd_req_ready, ring_rsp_ready},
            6'b000010);
        chk("rst_async_dat", {sd_rsp_info, ring_req_addr, ring_req_data, err_cnt}, '0);
        step();
        rst = 1'b0;
        ring_rsp_valid = 1'b1;
        ring_rsp_data  = 64'hCAFE;
        step();
        chk("post_idle", {ring_rsp_ready, busy}, 2'b00);
        sd_req_valid = 1'b1;
        sd_req_info  = mk(ST_RD, 40'h58, 64'h0);
        step();
        sd_req_valid = 1'b0;
        chk("post_req", {ring_rsp_ready, ring_req_valid, ring_req_addr}, {1'b0, 1'b1, 40'h58});
        step();
        step();
        ring_rsp_valid = 1'b0;
        chk("post_rsp", {sd_rsp_valid, sd_rsp_info}, {1'b1, mk(ST_RSP, 40'h58, 64'hCAFE)});
        hs();
        chk("post_done", {busy, err_cnt}, {1'b0, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
